// File: rtl/mem_port_arb.sv
// Arbiter sharing one byte-serial memory controller between the IF fetch port and the MEM load/store port.
// MEM has priority, a starvation counter forces IF through, and a jump flush cancels an in-flight fetch.
module mem_port_arb #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush,
    input  logic        if_re,
    input  logic [31:0] if_addr,
    input  logic [2:0]  if_len_in_byte,
    output logic        if_busy,
    output logic        if_done,
    output logic [31:0] if_r_data,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_w_data,
    input  logic [2:0]  mem_len_in_byte,
    output logic        mem_busy,
    output logic        mem_done,
    output logic [31:0] mem_r_data,
    output logic        mc_start,
    output logic        mc_we,
    output logic [31:0] mc_addr,
    output logic [31:0] mc_w_data,
    output logic [2:0]  mc_len_in_byte,
    input  logic        mc_done,
    input  logic [31:0] mc_r_data,
    output logic [1:0]  dbg_state,
    output logic [3:0]  dbg_starve_cnt
);
    typedef enum logic [1:0] {IDLE, SERVE_IF, SERVE_MEM, DRAIN} state_t;

    state_t      state, state_nx;
    logic [3:0]  starve_cnt, starve_nx;
    logic        start_pend, start_nx;
    logic        if_done_pend, if_done_nx;
    logic        mem_done_pend, mem_done_nx;
    logic        mc_we_nx;
    logic [31:0] mc_addr_nx, mc_w_data_nx;
    logic [2:0]  mc_len_nx;
    logic [31:0] if_r_data_nx, mem_r_data_nx;

    logic any_mem, force_if, grant_if, grant_mem, flush_ok;

    function automatic logic len_ok(input logic [2:0] len);
        return (len == 3'd1) || (len == 3'd2) || (len == 3'd4);
    endfunction

    assign any_mem  = mem_re | mem_we;
    assign force_if = if_re && (starve_cnt == 4'(STARVE_MAX));
    assign grant_if  = rdy_in && (state == IDLE) && if_re && !flush && (force_if || !any_mem);
    assign grant_mem = rdy_in && (state == IDLE) && any_mem && !grant_if;
    assign flush_ok  = flush && rdy_in;

    always_comb begin
        state_nx      = state;
        starve_nx     = starve_cnt;
        start_nx      = start_pend;
        if_done_nx    = if_done_pend;
        mem_done_nx   = mem_done_pend;
        mc_we_nx      = mc_we;
        mc_addr_nx    = mc_addr;
        mc_w_data_nx  = mc_w_data;
        mc_len_nx     = mc_len_in_byte;
        if_r_data_nx  = if_r_data;
        mem_r_data_nx = mem_r_data;

        // Pending pulses leave the block only in a ready cycle, then clear.
        if (rdy_in) begin
            start_nx    = 1'b0;
            if_done_nx  = 1'b0;
            mem_done_nx = 1'b0;
        end

        if (grant_if) begin
            mc_we_nx     = 1'b0;
            mc_addr_nx   = if_addr;
            mc_w_data_nx = 32'd0;
            mc_len_nx    = if_len_in_byte;
            starve_nx    = 4'd0;
            if (len_ok(if_len_in_byte)) begin
                start_nx = 1'b1;
                state_nx = SERVE_IF;
            end else begin
                if_done_nx   = 1'b1;
                if_r_data_nx = 32'd0;
            end
        end else if (grant_mem) begin
            mc_we_nx     = mem_we;
            mc_addr_nx   = mem_addr;
            mc_w_data_nx = mem_w_data;
            mc_len_nx    = mem_len_in_byte;
            if (!if_re)
                starve_nx = 4'd0;
            else if (starve_cnt != 4'(STARVE_MAX))
                starve_nx = starve_cnt + 4'd1;
            if (len_ok(mem_len_in_byte)) begin
                start_nx = 1'b1;
                state_nx = SERVE_MEM;
            end else begin
                mem_done_nx   = 1'b1;
                mem_r_data_nx = 32'd0;
            end
        end

        // mc_done is a single-cycle event the controller will not repeat, so it is
        // captured even while rdy_in is low; only the port's done pulse waits for rdy_in.
        case (state)
            SERVE_IF: begin
                if (mc_done) begin
                    state_nx = IDLE;
                    if (!flush_ok) begin
                        if_r_data_nx = mc_r_data;
                        if_done_nx   = 1'b1;
                    end
                end else if (flush_ok) begin
                    state_nx = DRAIN;
                end
            end
            SERVE_MEM: begin
                if (mc_done) begin
                    state_nx      = IDLE;
                    mem_r_data_nx = mc_we ? 32'd0 : mc_r_data;
                    mem_done_nx   = 1'b1;
                end
            end
            DRAIN: begin
                if (mc_done) state_nx = IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= IDLE;
            starve_cnt     <= 4'd0;
            start_pend     <= 1'b0;
            if_done_pend   <= 1'b0;
            mem_done_pend  <= 1'b0;
            mc_we          <= 1'b0;
            mc_addr        <= 32'd0;
            mc_w_data      <= 32'd0;
            mc_len_in_byte <= 3'd0;
            if_r_data      <= 32'd0;
            mem_r_data     <= 32'd0;
        end else begin
            state          <= state_nx;
            starve_cnt     <= starve_nx;
            start_pend     <= start_nx;
            if_done_pend   <= if_done_nx;
            mem_done_pend  <= mem_done_nx;
            mc_we          <= mc_we_nx;
            mc_addr        <= mc_addr_nx;
            mc_w_data      <= mc_w_data_nx;
            mc_len_in_byte <= mc_len_nx;
            if_r_data      <= if_r_data_nx;
            mem_r_data     <= mem_r_data_nx;
        end
    end

    assign mc_start       = start_pend & rdy_in;
    assign if_done        = if_done_pend & rdy_in;
    assign mem_done       = mem_done_pend & rdy_in;
    assign if_busy        = if_re && !if_done;
    assign mem_busy       = any_mem && !mem_done;
    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;
endmodule
